argmax_onehot_expander: RTL and testbench
=========================================

// Module: argmax_onehot_expander
// PURPOSE
//  Inverse end of the argmax reduction stream. Accepts one 32-bit index per transaction.
//  Emits DIM_SIZE elements serially: HOT_VALUE at position == index, COLD_VALUE elsewhere.
//  Feeds downstream elementwise/loss blocks that expect a dense one-hot tensor row.
//  Valid/ready on both sides; zero-bubble back-to-back vectors.
// PARAMETERS
//  DIM_SIZE    16            elements per emitted vector (>= 2)
//  DATA_W      32            width of index_in and output_data
//  HOT_VALUE   32'h3F800000  element value at the hot position (fp32 1.0)
//  COLD_VALUE  32'h00000000  element value at all other positions
// PORTS
//  clk          in   1       clock
//  rst_n        in   1       asynchronous active-low reset
//  valid_in     in   1       index_in valid
//  ready_in     out  1       expander can accept an index this cycle
//  index_in     in   DATA_W  hot position (unsigned)
//  valid_out    out  1       output_data valid
//  ready_out    in   1       downstream accepts output_data
//  output_data  out  DATA_W  current vector element
//  last_out     out  1       current element is position DIM_SIZE-1
//  err_out      out  1       only with ONEHOT_RANGE_CHECK_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, cnt=0, idx=0, valid_out=0,
//    last_out=0, output_data=COLD_VALUE, err_out=0, ready_in=1 after release.
//  - Regs: state {IDLE, EMIT}, cnt [$clog2(DIM_SIZE)-1:0], idx [DATA_W-1:0].
//  - Accept: a transfer occurs when valid_in && ready_in; idx<=index_in, cnt<=0, state<=EMIT.
//  - Handshake out: a beat transfers when valid_out && ready_out.
//  - IDLE: ready_in=1, valid_out=0.
//  - EMIT: valid_out=1. output_data = (idx == cnt, zero-extended compare) ? HOT_VALUE : COLD_VALUE.
//    last_out = (cnt == DIM_SIZE-1).
//  - EMIT on a beat with cnt < DIM_SIZE-1: cnt<=cnt+1.
//  - EMIT on the last beat: cnt<=0.
//    - Same-cycle valid_in: the new index is accepted; stay in EMIT, no idle cycle.
//    - No valid_in: state<=IDLE.
//  - ready_in = (state==IDLE) || (state==EMIT && last_out && ready_out).
//    This is the only input->output combinational path.
//  - Stall: ready_out=0 in EMIT holds cnt, idx, output_data and last_out stable.
//    valid_out never drops before its beat transfers.
//  - Latency: first element is valid on the cycle after index acceptance.
//    Sustained throughput: one index per DIM_SIZE cycles.
//  - All outputs are decoded from registers only, except ready_in.
//  - Index >= DIM_SIZE: the full vector is emitted as all COLD_VALUE, with normal last_out.
//  - Reset mid-vector: the partial vector is abandoned; no last_out.
//    After release the block is idle and takes a new index.
// CONFIGURATION
//  ONEHOT_RANGE_CHECK_EN defined:
//    - Adds port err_out.
//    - err_out=1 on every beat (valid_out=1) of a vector whose idx >= DIM_SIZE; 0 otherwise.
//    - err_out is stable under stall; reset value 0.
//  ONEHOT_RANGE_CHECK_EN undefined:
//    - err_out port and its logic are absent.
//    - Out-of-range indices still produce an all-COLD vector silently.
// TESTING
//  1. Reset: rst_n=0 mid-stream -> valid_out=0, last_out=0, output_data=0 immediately.
//     After release -> ready_in=1.
//  2. DIM_SIZE=16, index 5, ready_out=1 -> 16 beats; beat 5 = 32'h3F800000, others 0.
//     last_out only on beat 15; first beat one cycle after accept.
//  3. Indices 0 then 15 presented back-to-back, ready_out=1 -> second index accepted on
//     the last beat of the first vector; 32 consecutive valid beats, no bubble;
//     hot beats at positions 0 and 31.
//  4. Index 3, ready_out toggled 1,0,0,1,... -> each element held stable while stalled;
//     exactly 16 transfers; hot value on the 4th transfer only.
//  5. Index 20 (>= DIM_SIZE) -> 16 beats all 0, last_out on beat 15.
//     With ONEHOT_RANGE_CHECK_EN: err_out=1 on all 16 beats; err_out=0 for a following index 2.
//  6. valid_in=1 held continuously with ready_out=1 -> one index accepted every 16 cycles.
//     ready_in=0 except on last beats.

Source files
------------

// File: rtl/argmax_onehot_expander.sv
// Expands one index per transaction into a serial DIM_SIZE-element one-hot row.
// Optional range-error flag on err_out is enabled by defining ONEHOT_RANGE_CHECK_EN.
module argmax_onehot_expander #(
  parameter int                DIM_SIZE   = 16,
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] HOT_VALUE  = 32'h3F800000,
  parameter logic [DATA_W-1:0] COLD_VALUE = 32'h00000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [DATA_W-1:0] index_in,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [DATA_W-1:0] output_data,
  output logic              last_out
`ifdef ONEHOT_RANGE_CHECK_EN
  ,
  output logic              err_out
`endif
);

  // state  | meaning
  // S_IDLE | no vector in flight, ready_in asserted
  // S_EMIT | streaming elements of the accepted index, cnt_q is the position
  typedef enum logic {S_IDLE, S_EMIT} state_t;

  localparam int CNT_W = (DIM_SIZE > 1) ? $clog2(DIM_SIZE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIM_SIZE - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   idx_q, idx_d;

  logic emit;
  logic beat;
  logic accept;
  logic hot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Element outputs depend on registered state only; ready_in is the sole
  // combinational path, letting the next index land on the last beat.
  always_comb begin
    emit        = (state_q == S_EMIT);
    hot         = (idx_q == DATA_W'(cnt_q));
    valid_out   = emit;
    last_out    = emit && (cnt_q == CNT_LAST);
    output_data = (emit && hot) ? HOT_VALUE : COLD_VALUE;
    ready_in    = (state_q == S_IDLE) || (emit && last_out && ready_out);
  end

`ifdef ONEHOT_RANGE_CHECK_EN
  always_comb begin
    err_out = emit && (idx_q >= DATA_W'(DIM_SIZE));
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    beat    = valid_out && ready_out;
    accept  = valid_in && ready_in;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          idx_d   = index_in;
          cnt_d   = '0;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (beat) begin
          if (last_out) begin
            cnt_d = '0;
            if (accept) begin
              idx_d = index_in;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_argmax_onehot_expander.sv
// Self-checking bench: directed scenarios plus random traffic against a beat-queue model.
module tb_argmax_onehot_expander;
  localparam int          DIM  = 16;
  localparam logic [31:0] HOT  = 32'h3F800000;
  localparam logic [31:0] COLD = 32'h00000000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic        ready_in;
  logic [31:0] index_in;
  logic        valid_out;
  logic        ready_out;
  logic [31:0] output_data;
  logic        last_out;
`ifdef ONEHOT_RANGE_CHECK_EN
  logic        err_out;
`endif

  argmax_onehot_expander dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_in(ready_in),
    .index_in(index_in), .valid_out(valid_out), .ready_out(ready_out),
    .output_data(output_data), .last_out(last_out)
`ifdef ONEHOT_RANGE_CHECK_EN
    , .err_out(err_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        err;
  } beat_t;

  beat_t q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    beats = 0;
  int    cyc = 0;
  logic  acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_vector(input logic [31:0] idx);
    beat_t b;
    for (int p = 0; p < DIM; p++) begin
      b.data = (idx == 32'(p)) ? HOT : COLD;
      b.last = (p == DIM - 1);
      b.err  = (idx >= 32'(DIM));
      q.push_back(b);
    end
  endtask

  // One clock: compare at negedge, advance the model at posedge, drive after #1.
  task automatic tick();
    logic exp_valid, exp_rdy;
    @(negedge clk);
    exp_valid = (q.size() > 0);
    exp_rdy   = (q.size() == 0) || (q.size() == 1 && ready_out);
    chk("ready_in", {31'b0, ready_in}, {31'b0, exp_rdy});
    chk("valid_out", {31'b0, valid_out}, {31'b0, exp_valid});
    if (exp_valid) begin
      chk("data", output_data, q[0].data);
      chk("last", {31'b0, last_out}, {31'b0, q[0].last});
`ifdef ONEHOT_RANGE_CHECK_EN
      chk("err", {31'b0, err_out}, {31'b0, q[0].err});
`endif
    end
    @(posedge clk);
    cyc++;
    if (exp_valid && ready_out) begin
      void'(q.pop_front());
      beats++;
    end
    acc = valid_in && exp_rdy;
    if (acc) push_vector(index_in);
    #1;
  endtask

  task automatic send(input logic [31:0] idx);
    int n = 0;
    valid_in = 1'b1;
    index_in = idx;
    do begin
      tick();
      n++;
    end while (!acc && n < 100);
    chk("send_accept", {31'b0, acc}, 32'd1);
    valid_in = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 500) begin
      tick();
      n++;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int b0, last_acc;
    rst_n = 1'b0; valid_in = 1'b0; index_in = '0; ready_out = 1'b1; acc = 1'b0;
    #23;
    chk("rst_valid", {31'b0, valid_out}, 32'd0);
    chk("rst_data", output_data, COLD);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // index 5, free-flowing
    send(32'd5);
    drain();

    // back-to-back 0 then 15, no bubble expected
    send(32'd0);
    b0 = beats;
    send(32'd15);
    drain();
    chk("b2b_beats", 32'(beats - b0), 32'd32);

    // stall pattern 1,0,0 on ready_out
    send(32'd3);
    b0 = beats;
    for (int k = 0; k < 200 && q.size() > 0; k++) begin
      ready_out = (k % 3 == 0);
      tick();
    end
    ready_out = 1'b1;
    chk("stall_transfers", 32'(beats - b0), 32'd16);
    chk("stall_empty", 32'(q.size()), 32'd0);

    // out-of-range then in-range
    send(32'd20);
    send(32'd2);
    drain();

    // continuous valid_in: one accept per DIM cycles
    valid_in = 1'b1;
    last_acc = -1;
    for (int c = 0; c < 5 * DIM; c++) begin
      index_in = $urandom_range(0, DIM - 1);
      tick();
      if (acc) begin
        if (last_acc >= 0) chk("thru_gap", 32'(c - last_acc), 32'(DIM));
        last_acc = c;
      end
    end
    valid_in = 1'b0;
    drain();

    // random traffic including out-of-range indices and stalls
    for (int c = 0; c < 600; c++) begin
      valid_in  = ($urandom_range(0, 1) == 1);
      index_in  = $urandom_range(0, DIM + 7);
      ready_out = ($urandom_range(0, 3) != 0);
      tick();
    end
    valid_in = 1'b0;
    ready_out = 1'b1;
    drain();

    // reset mid-vector abandons the partial row
    send(32'd7);
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, valid_out}, 32'd0);
    chk("midrst_last", {31'b0, last_out}, 32'd0);
    chk("midrst_data", output_data, COLD);
`ifdef ONEHOT_RANGE_CHECK_EN
    chk("midrst_err", {31'b0, err_out}, 32'd0);
`endif
    q.delete();
    @(negedge clk); rst_n = 1'b1;
    tick();
    send(32'd9);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
